// File: rtl/display_spi_master.sv
// display_spi_master
// Host-side SPI mode-0 frame transmitter for the display link. On start it
// reads rows x columns pixels row-major from a synchronous-read pixel store
// and shifts each one out MSB-first. The whole frame sits inside a single ss
// low period.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start          : frame request, sampled only in IDLE
//   busy, done     : frame in progress / one-cycle completion pulse
//   rrow, rcol     : pixel read address
//   rdata          : pixel data, valid one cycle after the address
//   sclk, ss, mosi : SPI pins (sclk idles low, ss active-low)
//
// Optional build macro: DISPLAY_SPI_HEADER_EN sends a 0xA5 header byte
// before pixel (0,0).
module display_spi_master #(
  parameter int rows       = 8,
  parameter int columns    = 32,
  parameter int pixelwidth = 16,
  parameter int clkdiv     = 4,
  localparam int RW = (rows > 1) ? $clog2(rows) : 1,
  localparam int CLW = (columns > 1) ? $clog2(columns) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [RW-1:0]         rrow,
  output logic [CLW-1:0]        rcol,
  input  logic [pixelwidth-1:0] rdata,
  output logic                  sclk,
  output logic                  ss,
  output logic                  mosi
);

  localparam int CW = $clog2(2 * clkdiv);
  localparam int BW = $clog2(pixelwidth);
  localparam logic [CW-1:0]  DIV_LAST = CW'(clkdiv - 1);
  localparam logic [CW-1:0]  GAP_LAST = CW'(2 * clkdiv - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(rows - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(columns - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, HOLD, GAP} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           cnt;
  logic                    phase;     // 0: sclk low half, 1: sclk high half
  logic [BW-1:0]           bit_cnt;
  logic [pixelwidth-1:0]   sreg;
  logic                    last_px;   // pixel being shifted is the final one
  logic                    in_hdr;
  logic                    div_end;
  logic                    bit_done;
  logic                    bit_last;
  logic                    prefetch;

`ifdef DISPLAY_SPI_HEADER_EN
  localparam logic [pixelwidth-1:0] HDR_WORD = pixelwidth'(8'hA5) << (pixelwidth - 8);
  logic                    hdr;
  logic [pixelwidth-1:0]   pend;      // pixel (0,0) parked while the header goes out
  assign in_hdr = hdr;
`else
  assign in_hdr = 1'b0;
`endif

  always_comb begin
    div_end  = (cnt == DIV_LAST);
    bit_done = (state == SHIFT) && div_end && phase;
    bit_last = in_hdr ? (bit_cnt == BW'(7)) : (bit_cnt == BW'(pixelwidth - 1));
    // Entering the last bit of a pixel: present the next address so rdata
    // is ready at that bit's falling edge and sclk never stretches.
    prefetch = bit_done && !in_hdr && (bit_cnt == BW'(pixelwidth - 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    ss         = !((state == FETCH) || (state == SHIFT) || (state == HOLD));
    sclk       = (state == SHIFT) && phase;
    mosi       = (state == SHIFT) && sreg[pixelwidth-1];
    done       = (state == GAP) && (cnt == GAP_LAST);
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (cnt == CW'(1)) state_next = SHIFT;
      SHIFT:   if (bit_done && bit_last && !in_hdr && last_px) state_next = HOLD;
      HOLD:    if (div_end) state_next = GAP;
      GAP:     if (cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      sreg    <= '0;
      last_px <= 1'b0;
      rrow    <= '0;
      rcol    <= '0;
`ifdef DISPLAY_SPI_HEADER_EN
      hdr     <= 1'b0;
      pend    <= '0;
`endif
    end else begin
      if (state == IDLE || state_next != state || (state == SHIFT && div_end))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            rrow    <= '0;
            rcol    <= '0;
            last_px <= 1'b0;
          end
        end
        FETCH: begin
          if (cnt == CW'(1)) begin
            phase   <= 1'b0;
            bit_cnt <= '0;
`ifdef DISPLAY_SPI_HEADER_EN
            hdr     <= 1'b1;
            pend    <= rdata;
            sreg    <= HDR_WORD;
`else
            sreg    <= rdata;
`endif
          end
        end
        SHIFT: begin
          if (div_end) begin
            phase <= ~phase;
            if (phase) begin
              if (bit_last) begin
                bit_cnt <= '0;
`ifdef DISPLAY_SPI_HEADER_EN
                if (hdr) begin
                  hdr  <= 1'b0;
                  sreg <= pend;
                end else
`endif
                sreg <= rdata;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                sreg    <= {sreg[pixelwidth-2:0], 1'b0};
              end
            end
          end
          if (prefetch) begin
            if (rrow == ROW_LAST && rcol == COL_LAST) begin
              last_px <= 1'b1;
            end else if (rcol == COL_LAST) begin
              rcol <= '0;
              rrow <= rrow + RW'(1);
            end else begin
              rcol <= rcol + CLW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
